// File: rtl/nor_zero_run_detect.sv
// nor_zero_run_detect: registered zero-run counter over NOR-reduced words with valid/ready output.
// Define NOR_ZERO_RUN_SAT_EN to saturate run_len at its maximum instead of wrapping.
module nor_zero_run_detect #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_nor,
  output logic [CNT_W-1:0] run_len,
  output logic             run_hit
);
  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
`ifdef NOR_ZERO_RUN_SAT_EN
  localparam logic [CNT_W-1:0] TOP = MAX;
`else
  localparam logic [CNT_W-1:0] TOP = '0;
`endif
  state_t state, state_nx;
  logic z, acc, valid_nx, nor_nx;
  logic [CNT_W-1:0] base, len_nx;
  assign in_ready = rst_n & (~out_valid | out_ready);
  assign run_hit = state == HIT;
  // clear takes effect before the accepted word is counted
  always_comb begin
    z = ~|in;
    acc = in_valid & in_ready;
    base = clear ? '0 : run_len;
    len_nx = acc ? (z ? (base == MAX ? TOP : base + 1'b1) : '0) : base;
    state_nx = len_nx == '0 ? IDLE : len_nx < THR ? RUN : HIT;
    valid_nx = acc ? 1'b1 : out_ready ? 1'b0 : out_valid;
    nor_nx = acc ? z : out_nor;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      run_len <= '0;
      out_valid <= 1'b0;
      out_nor <= 1'b0;
    end else begin
      state <= state_nx;
      run_len <= len_nx;
      out_valid <= valid_nx;
      out_nor <= nor_nx;
    end
  end
endmodule

// File: tb/tb_nor_zero_run_detect.sv
// tb_nor_zero_run_detect: directed vector table plus a narrow-counter wrap/saturate sequence.
module tb_nor_zero_run_detect;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, clear, out_ready, in_ready, out_valid, out_nor, run_hit;
  logic [3:0] in;
  logic [7:0] run_len;
  logic rst3_n, iv3, ir3, ov3, nor3, hit3;
  logic [2:0] len3;
  int checks = 0, errors = 0;
  nor_zero_run_detect #(.WIDTH(4), .CNT_W(8), .THRESH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_nor(out_nor),
    .run_len(run_len), .run_hit(run_hit));
  nor_zero_run_detect #(.WIDTH(4), .CNT_W(3), .THRESH(3)) d3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(iv3), .in_ready(ir3), .in(4'h0),
    .clear(1'b0), .out_valid(ov3), .out_ready(1'b1), .out_nor(nor3),
    .run_len(len3), .run_hit(hit3));
  typedef struct {
    logic rst_n, iv;
    logic [3:0] in;
    logic clr, ordy, e_ir, e_ov, e_nor;
    logic [7:0] e_len;
    logic e_hit;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask
  initial begin
    rst_n = 0; in_valid = 0; in = 0; clear = 0; out_ready = 1;
    rst3_n = 0; iv3 = 0;
    // rst_n iv in clr ordy | in_ready out_valid out_nor run_len run_hit
    v.push_back('{0,0,4'h0,0,1, 0,0,0,8'd0,0});
    v.push_back('{0,1,4'h0,0,1, 0,0,0,8'd0,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd1,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd2,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd3,1});
    v.push_back('{1,1,4'h4,0,1, 1,1,0,8'd0,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd1,0});
    v.push_back('{1,0,4'h0,0,1, 1,0,1,8'd1,0});
    v.push_back('{1,1,4'h0,0,0, 1,1,1,8'd2,0});
    v.push_back('{1,1,4'h0,0,0, 0,1,1,8'd2,0});
    v.push_back('{1,1,4'hf,0,0, 0,1,1,8'd2,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd3,1});
    v.push_back('{1,1,4'h8,0,1, 1,1,0,8'd0,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd1,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd2,0});
    v.push_back('{1,1,4'h0,1,1, 1,1,1,8'd1,0});
    v.push_back('{1,0,4'h0,1,0, 0,1,1,8'd0,0});
    v.push_back('{1,1,4'h0,1,1, 1,1,1,8'd1,0});
    v.push_back('{1,1,4'h2,1,1, 1,1,0,8'd0,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd1,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd2,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd3,1});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd4,1});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd5,1});
    v.push_back('{0,1,4'h0,0,1, 0,0,0,8'd0,0});
    v.push_back('{1,0,4'h0,0,1, 1,0,0,8'd0,0});
    v.push_back('{1,1,4'h0,0,1, 1,1,1,8'd1,0});
    @(posedge clk); #1;
    foreach (v[i]) begin
      rst_n = v[i].rst_n; in_valid = v[i].iv; in = v[i].in; clear = v[i].clr; out_ready = v[i].ordy;
      #1 chk("in_ready", i, 8'(in_ready), 8'(v[i].e_ir));
      @(posedge clk); #1;
      chk("out_valid", i, 8'(out_valid), 8'(v[i].e_ov));
      chk("out_nor", i, 8'(out_nor), 8'(v[i].e_nor));
      chk("run_len", i, run_len, v[i].e_len);
      chk("run_hit", i, 8'(run_hit), 8'(v[i].e_hit));
    end
    in_valid = 0;
    // narrow counter: nine zero words exercise the wrap or saturate path
    rst3_n = 1; iv3 = 1;
    for (int i = 1; i <= 9; i++) begin
      logic [7:0] el;
`ifdef NOR_ZERO_RUN_SAT_EN
      el = i > 7 ? 8'd7 : 8'(i);
`else
      el = i > 7 ? 8'(i - 8) : 8'(i);
`endif
      @(posedge clk); #1;
      chk("w3_valid", i, 8'(ov3), 8'd1);
      chk("w3_run_len", i, 8'(len3), el);
      chk("w3_run_hit", i, 8'(hit3), 8'(el >= 8'd3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
